multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/control_pkg.sv | 65 ++++++
 rtl/instruction_decoder.sv | 87 ++++++++
 rtl/multicycle_control.sv | 147 ++++++++++++++
 tb/tb_multicycle_control.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared constants and decode bundle for the multicycle RV32I controller.
// Opcodes, select codes and FSM state encodings live here.
package control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd12;
  localparam logic [3:0] ALU_SRA   = 4'd13;
  localparam logic [3:0] ALU_PASSB = 4'd15;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_I    = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_TRAP      = 3'd5;

  typedef struct packed {
    logic [2:0] imm_sel;
    logic       a_sel;
    logic       b_sel;
    logic [3:0] alu_sel;
    logic [2:0] mem_split;
    logic [1:0] wb_sel;
    logic       illegal;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
  } dec_t;

  // ALU codes for add..and coincide with funct3
  function automatic logic [3:0] alu_op(
    input logic [2:0] f3,
    input logic       alt
  );
    if (alt && f3 == 3'b000) return ALU_SUB;
    if (alt && f3 == 3'b101) return ALU_SRA;
    return {1'b0, f3};
  endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Combinational field decode of the latched instruction word:
// datapath selects, instruction class and the illegal flag.
module instruction_decoder
  import control_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_bits;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    dec = '0;
    dec.alu_sel = ALU_ADD;
    dec.wb_sel = WB_ALU;
    unique case (1'b1)
      (op == OP_R): begin
        dec.alu_sel = alu_op(f3, f7[5]);
        dec.illegal = !(f7 == F7_BASE ||
          (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
      end
      (op == OP_I): begin
        dec.imm_sel = IMM_I;
        dec.b_sel = 1'b1;
        dec.alu_sel = alu_op(f3, f3 == 3'b101 && f7[5]);
        dec.illegal = (f3 == 3'b001 && f7 != F7_BASE) ||
          (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT);
      end
      (op == OP_LOAD): begin
        dec.imm_sel = IMM_I;
        dec.b_sel = 1'b1;
        dec.mem_split = f3;
        dec.wb_sel = WB_MEM;
        dec.is_load = 1'b1;
        dec.illegal = f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
      end
      (op == OP_STORE): begin
        dec.imm_sel = IMM_S;
        dec.b_sel = 1'b1;
        dec.mem_split = f3;
        dec.is_store = 1'b1;
        dec.illegal = f3 > 3'b010;
      end
      (op == OP_BRANCH): begin
        dec.imm_sel = IMM_B;
        dec.a_sel = 1'b1;
        dec.b_sel = 1'b1;
        dec.is_branch = 1'b1;
        dec.illegal = f3 == 3'b010 || f3 == 3'b011;
      end
      (op == OP_JAL): begin
        dec.imm_sel = IMM_J;
        dec.a_sel = 1'b1;
        dec.b_sel = 1'b1;
        dec.wb_sel = WB_PC4;
        dec.is_jump = 1'b1;
      end
      (op == OP_JALR): begin
        dec.imm_sel = IMM_I;
        dec.b_sel = 1'b1;
        dec.wb_sel = WB_PC4;
        dec.is_jump = 1'b1;
        dec.illegal = f3 != 3'b000;
      end
      (op == OP_LUI): begin
        dec.imm_sel = IMM_U;
        dec.b_sel = 1'b1;
        dec.alu_sel = ALU_PASSB;
      end
      (op == OP_AUIPC): begin
        dec.imm_sel = IMM_U;
        dec.a_sel = 1'b1;
        dec.b_sel = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM with instruction register,
// memory wait counter and sticky trap causes.
module multicycle_control
  import control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT     = 15,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        instr_write_enable,
  output logic        pc_write_enable,
  output logic        register_write_enable,
  output logic        memory_write_enable,
  output logic        pc_select,
  output logic [2:0]  immediate_select,
  output logic        a_select,
  output logic        b_select,
  output logic [3:0]  alu_select,
  output logic [2:0]  memory_split_option,
  output logic [1:0]  write_back_select,
  output logic        illegal_instruction,
  output logic        timeout,
  output logic [2:0]  state
);

  localparam logic [7:0] TMO_LIM = 8'(MEM_TIMEOUT);

  logic [2:0]  state_q;
  logic [2:0]  nxt;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_inc;
  logic [31:0] ir_q;
  logic        ill_q;
  logic        tmo_q;
  logic        req;
  logic        iwe;
  logic        pwe;
  logic        rwe;
  logic        mwe;
  logic        psel;
  logic        ill_trap;
  logic        tmo_trap;
  dec_t        dec;

  instruction_decoder u_dec (
    .instr (ir_q),
    .dec   (dec)
  );

  assign cnt_inc = cnt_q + 8'd1;
  assign tmo_trap = req && !mem_ready && cnt_inc == TMO_LIM;
  assign ill_trap = state_q == S_DECODE && dec.illegal &&
    TRAP_ON_ILLEGAL;

  always_comb begin
    nxt = state_q;
    req = 1'b0;
    iwe = 1'b0;
    pwe = 1'b0;
    rwe = 1'b0;
    mwe = 1'b0;
    psel = 1'b0;
    case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (mem_ready) begin
          iwe = 1'b1;
          nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec.illegal)
          nxt = TRAP_ON_ILLEGAL ? S_TRAP : S_WRITEBACK;
        else
          nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (dec.is_branch) begin
          pwe = 1'b1;
          psel = branch_taken;
          nxt = S_FETCH;
        end else if (dec.is_load || dec.is_store) begin
          nxt = S_MEMORY;
        end else begin
          nxt = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        req = 1'b1;
        mwe = dec.is_store;
        if (mem_ready) begin
          pwe = dec.is_store;
          nxt = dec.is_store ? S_FETCH : S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        // an illegal op reaching here is a NOP: advance PC only
        rwe = !dec.illegal;
        pwe = 1'b1;
        psel = dec.is_jump && !dec.illegal;
        nxt = S_FETCH;
      end
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_TRAP;
    endcase
    if (tmo_trap) nxt = S_TRAP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q <= '0;
      ir_q <= '0;
      ill_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= nxt;
      if (iwe) ir_q <= instruction;
      if (mem_ready || nxt != state_q) cnt_q <= '0;
      else if (req) cnt_q <= cnt_inc;
      if (ill_trap) ill_q <= 1'b1;
      if (tmo_trap) tmo_q <= 1'b1;
    end
  end

  assign mem_req = !rst && req;
  assign instr_write_enable = !rst && iwe;
  assign pc_write_enable = !rst && pwe;
  assign register_write_enable = !rst && rwe;
  assign memory_write_enable = !rst && mwe;
  assign pc_select = !rst && psel;
  assign immediate_select = rst ? IMM_NONE : dec.imm_sel;
  assign a_select = !rst && dec.a_sel;
  assign b_select = !rst && dec.b_sel;
  assign alu_select = rst ? ALU_ADD : dec.alu_sel;
  assign memory_split_option = rst ? 3'b000 : dec.mem_split;
  assign write_back_select = rst ? WB_MEM : dec.wb_sel;
  assign illegal_instruction = !rst && ill_q;
  assign timeout = !rst && tmo_q;
  assign state = rst ? S_FETCH : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one trapping instance with
// default parameters, one NOP-on-illegal instance with MEM_TIMEOUT=4.
module tb_multicycle_control;
  import control_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        branch_taken;
  logic        mem_ready;

  logic       req_t, iwe_t, pwe_t, rwe_t, mwe_t, psel_t, asel_t, bsel_t;
  logic [2:0] imm_t, split_t, st_t;
  logic [3:0] alu_t;
  logic [1:0] wb_t;
  logic       ill_t, tmo_t;

  logic       req_n, iwe_n, pwe_n, rwe_n, mwe_n, psel_n, asel_n, bsel_n;
  logic [2:0] imm_n, split_n, st_n;
  logic [3:0] alu_n;
  logic [1:0] wb_n;
  logic       ill_n, tmo_n;

  int checks;
  int errors;

  multicycle_control u_trap (
    .clk (clk), .rst (rst), .instruction (instruction),
    .branch_taken (branch_taken), .mem_ready (mem_ready),
    .mem_req (req_t), .instr_write_enable (iwe_t),
    .pc_write_enable (pwe_t), .register_write_enable (rwe_t),
    .memory_write_enable (mwe_t), .pc_select (psel_t),
    .immediate_select (imm_t), .a_select (asel_t),
    .b_select (bsel_t), .alu_select (alu_t),
    .memory_split_option (split_t), .write_back_select (wb_t),
    .illegal_instruction (ill_t), .timeout (tmo_t), .state (st_t)
  );

  multicycle_control #(
    .MEM_TIMEOUT (4),
    .TRAP_ON_ILLEGAL (1'b0)
  ) u_nop (
    .clk (clk), .rst (rst), .instruction (instruction),
    .branch_taken (branch_taken), .mem_ready (mem_ready),
    .mem_req (req_n), .instr_write_enable (iwe_n),
    .pc_write_enable (pwe_n), .register_write_enable (rwe_n),
    .memory_write_enable (mwe_n), .pc_select (psel_n),
    .immediate_select (imm_n), .a_select (asel_n),
    .b_select (bsel_n), .alu_select (alu_n),
    .memory_split_option (split_n), .write_back_select (wb_n),
    .illegal_instruction (ill_n), .timeout (tmo_n), .state (st_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic rdy, input logic bt);
    @(negedge clk);
    mem_ready = rdy;
    branch_taken = bt;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    instruction = 32'h002081B3;
    #1;
    checks++;
    if ({req_t, iwe_t, pwe_t, rwe_t, mwe_t, psel_t, imm_t, asel_t, bsel_t,
         alu_t, split_t, wb_t, ill_t, tmo_t, st_t} !== '0) begin
      errors++;
      $display("FAIL reset_outs_t: got req=%b st=%0d alu=%0d want all 0",
               req_t, st_t, alu_t);
    end
    checks++;
    if ({req_n, iwe_n, pwe_n, rwe_n, mwe_n, psel_n, imm_n, asel_n, bsel_n,
         alu_n, split_n, wb_n, ill_n, tmo_n, st_n} !== '0) begin
      errors++;
      $display("FAIL reset_outs_n: got req=%b st=%0d want all 0",
               req_n, st_n);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    mem_ready = 1'b0;
    cyc(1'b0, 1'b0);
    checks++;
    if (st_t !== S_FETCH || req_t !== 1'b1 || iwe_t !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: st=%0d req=%b iwe=%b want 0 1 0",
               st_t, req_t, iwe_t);
    end
    checks++;
    if (ill_t !== 1'b0 || tmo_t !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ill=%b tmo=%b want 0 0", ill_t, tmo_t);
    end
  endtask

  task automatic test_add();
    logic [2:0] exp_st [5] = '{S_FETCH, S_DECODE, S_EXECUTE,
                               S_WRITEBACK, S_FETCH};
    int rwe_cnt = 0;
    apply_reset();
    instruction = 32'h002081B3;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0);
      if (rwe_t === 1'b1) rwe_cnt++;
      checks++;
      if (st_t !== exp_st[i]) begin
        errors++;
        $display("FAIL add_state[%0d]: got %0d want %0d", i, st_t, exp_st[i]);
      end
      if (i == 1) begin
        checks++;
        if ({req_t, iwe_t, pwe_t, rwe_t, mwe_t} !== 5'b0 ||
            alu_t !== 4'd0) begin
          errors++;
          $display("FAIL add_decode: strobes=%b alu=%0d want 0 0",
                   {req_t, iwe_t, pwe_t, rwe_t, mwe_t}, alu_t);
        end
      end
      if (i == 3) begin
        checks++;
        if (wb_t !== 2'b01 || pwe_t !== 1'b1 || psel_t !== 1'b0) begin
          errors++;
          $display("FAIL add_wb: wb=%b pwe=%b psel=%b want 01 1 0",
                   wb_t, pwe_t, psel_t);
        end
      end
    end
    checks++;
    if (rwe_cnt != 1) begin
      errors++;
      $display("FAIL add_rwe_count: got %0d want 1", rwe_cnt);
    end
  endtask

  task automatic test_load();
    logic       rdy [9] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    logic [2:0] exp_st [9] = '{S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY,
                               S_MEMORY, S_MEMORY, S_MEMORY,
                               S_WRITEBACK, S_FETCH};
    int req_cnt = 0;
    apply_reset();
    instruction = 32'h0000A103;
    for (int i = 0; i < 9; i++) begin
      cyc(rdy[i], 1'b0);
      checks++;
      if (st_t !== exp_st[i]) begin
        errors++;
        $display("FAIL lw_state[%0d]: got %0d want %0d", i, st_t, exp_st[i]);
      end
      if (st_t === S_MEMORY) begin
        if (req_t === 1'b1) req_cnt++;
        checks++;
        if (split_t !== 3'b010 || mwe_t !== 1'b0) begin
          errors++;
          $display("FAIL lw_mem: split=%b mwe=%b want 010 0", split_t, mwe_t);
        end
      end
      if (i == 7) begin
        checks++;
        if (wb_t !== 2'b00 || rwe_t !== 1'b1) begin
          errors++;
          $display("FAIL lw_wb: wb=%b rwe=%b want 00 1", wb_t, rwe_t);
        end
      end
    end
    checks++;
    if (req_cnt != 4) begin
      errors++;
      $display("FAIL lw_req_cycles: got %0d want 4", req_cnt);
    end
  endtask

  task automatic test_branch(input logic bt);
    apply_reset();
    instruction = 32'h00000463;
    cyc(1'b1, bt);
    cyc(1'b0, bt);
    cyc(1'b0, bt);
    checks++;
    if (st_t !== S_EXECUTE || imm_t !== 3'b011 || pwe_t !== 1'b1 ||
        psel_t !== bt || asel_t !== 1'b1 || bsel_t !== 1'b1) begin
      errors++;
      $display("FAIL beq_exec(bt=%b): st=%0d imm=%b pwe=%b psel=%b a=%b b=%b",
               bt, st_t, imm_t, pwe_t, psel_t, asel_t, bsel_t);
    end
    cyc(1'b0, bt);
    checks++;
    if (st_t !== S_FETCH || rwe_t !== 1'b0) begin
      errors++;
      $display("FAIL beq_next(bt=%b): st=%0d rwe=%b want 0 0",
               bt, st_t, rwe_t);
    end
  endtask

  task automatic test_jal();
    apply_reset();
    instruction = 32'h000000EF;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    checks++;
    if (st_t !== S_WRITEBACK || wb_t !== 2'b10 || psel_t !== 1'b1 ||
        rwe_t !== 1'b1 || imm_t !== 3'b101) begin
      errors++;
      $display("FAIL jal_wb: st=%0d wb=%b psel=%b rwe=%b imm=%b",
               st_t, wb_t, psel_t, rwe_t, imm_t);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    instruction = 32'h0000007F;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    checks++;
    if (st_t !== S_DECODE || {req_t, iwe_t, pwe_t, rwe_t, mwe_t} !== 5'b0) begin
      errors++;
      $display("FAIL ill_decode: st=%0d strobes=%b", st_t,
               {req_t, iwe_t, pwe_t, rwe_t, mwe_t});
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (st_t !== S_TRAP || ill_t !== 1'b1) begin
      errors++;
      $display("FAIL ill_trap: st=%0d ill=%b want 5 1", st_t, ill_t);
    end
    checks++;
    if (st_n !== S_WRITEBACK || rwe_n !== 1'b0 || pwe_n !== 1'b1 ||
        psel_n !== 1'b0 || ill_n !== 1'b0) begin
      errors++;
      $display("FAIL ill_nop: st=%0d rwe=%b pwe=%b psel=%b ill=%b",
               st_n, rwe_n, pwe_n, psel_n, ill_n);
    end
    cyc(1'b1, 1'b0);
    checks++;
    if (st_t !== S_TRAP || req_t !== 1'b0 || ill_t !== 1'b1) begin
      errors++;
      $display("FAIL ill_hold: st=%0d req=%b ill=%b want 5 0 1",
               st_t, req_t, ill_t);
    end
    checks++;
    if (st_n !== S_FETCH) begin
      errors++;
      $display("FAIL ill_nop_next: st=%0d want 0", st_n);
    end
    apply_reset();
    cyc(1'b0, 1'b0);
    checks++;
    if (ill_t !== 1'b0 || st_t !== S_FETCH) begin
      errors++;
      $display("FAIL ill_clear: ill=%b st=%0d want 0 0", ill_t, st_t);
    end
  endtask

  task automatic test_decode_table();
    logic [31:0] ins [10] = '{32'h4010D093, 32'h40109093, 32'h402081B3,
                              32'h4020C1B3, 32'h0000B103, 32'h0020B023,
                              32'h00002463, 32'h00001067, 32'h123450B7,
                              32'h0000A023};
    logic        ill [10] = '{0, 1, 0, 1, 1, 1, 1, 1, 0, 0};
    logic [3:0]  alu [10] = '{4'd13, 4'd0, 4'd12, 4'd0, 4'd0, 4'd0,
                              4'd0, 4'd0, 4'd15, 4'd0};
    for (int i = 0; i < 10; i++) begin
      apply_reset();
      instruction = ins[i];
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      if (!ill[i]) begin
        checks++;
        if (alu_t !== alu[i]) begin
          errors++;
          $display("FAIL dec_alu[%0d]: got %0d want %0d", i, alu_t, alu[i]);
        end
      end
      cyc(1'b0, 1'b0);
      checks++;
      if (st_t !== (ill[i] ? S_TRAP : S_EXECUTE)) begin
        errors++;
        $display("FAIL dec_ill[%0d]: st=%0d want %0d", i, st_t,
                 ill[i] ? S_TRAP : S_EXECUTE);
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    instruction = 32'h002081B3;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
    checks++;
    if (st_n !== S_FETCH || tmo_n !== 1'b0) begin
      errors++;
      $display("FAIL tmo_before: st=%0d tmo=%b want 0 0", st_n, tmo_n);
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (st_n !== S_TRAP || tmo_n !== 1'b1 || req_n !== 1'b0) begin
      errors++;
      $display("FAIL tmo_trap: st=%0d tmo=%b req=%b want 5 1 0",
               st_n, tmo_n, req_n);
    end
    checks++;
    if (st_t !== S_FETCH || tmo_t !== 1'b0) begin
      errors++;
      $display("FAIL tmo_default: st=%0d tmo=%b want 0 0", st_t, tmo_t);
    end
    apply_reset();
    cyc(1'b0, 1'b0);
    checks++;
    if (st_n !== S_FETCH || tmo_n !== 1'b0 || ill_n !== 1'b0 ||
        req_n !== 1'b1) begin
      errors++;
      $display("FAIL tmo_reset: st=%0d tmo=%b ill=%b req=%b",
               st_n, tmo_n, ill_n, req_n);
    end
    apply_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    checks++;
    if (st_n !== S_DECODE || tmo_n !== 1'b0) begin
      errors++;
      $display("FAIL tmo_ready_wins: st=%0d tmo=%b want 1 0", st_n, tmo_n);
    end
  endtask

  task automatic test_store();
    apply_reset();
    instruction = 32'h0020A023;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    checks++;
    if (st_t !== S_MEMORY || mwe_t !== 1'b1 || req_t !== 1'b1 ||
        split_t !== 3'b010 || pwe_t !== 1'b0) begin
      errors++;
      $display("FAIL sw_mem: st=%0d mwe=%b req=%b split=%b pwe=%b",
               st_t, mwe_t, req_t, split_t, pwe_t);
    end
    cyc(1'b1, 1'b0);
    checks++;
    if (mwe_t !== 1'b1 || pwe_t !== 1'b1 || psel_t !== 1'b0) begin
      errors++;
      $display("FAIL sw_ack: mwe=%b pwe=%b psel=%b want 1 1 0",
               mwe_t, pwe_t, psel_t);
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (st_t !== S_FETCH) begin
      errors++;
      $display("FAIL sw_next: st=%0d want 0", st_t);
    end
    apply_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (mwe_t !== 1'b0 || req_t !== 1'b0) begin
      errors++;
      $display("FAIL sw_rst_edge: mwe=%b req=%b want 0 0", mwe_t, req_t);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b0, 1'b0);
    checks++;
    if (st_t !== S_FETCH || req_t !== 1'b1 || split_t !== 3'b000 ||
        imm_t !== 3'b000) begin
      errors++;
      $display("FAIL sw_rst_after: st=%0d req=%b split=%b imm=%b",
               st_t, req_t, split_t, imm_t);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    instruction = '0;
    branch_taken = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_add();
    test_load();
    test_branch(1'b1);
    test_branch(1'b0);
    test_jal();
    test_illegal();
    test_decode_table();
    test_timeout();
    test_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
